// File: rtl/counter_mode_sequencer.sv
// counter_mode_sequencer: four-mode counter (binary up/down, BCD, ring) with a start/stop/switch control FSM.
module counter_mode_sequencer (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [1:0] Mode_req,
   input  logic       Mode_load,
   input  logic       Start,
   input  logic       Stop,
   input  logic       Tick,
   output logic [3:0] D,
   output logic [3:0] Count,
   output logic       Busy,
   output logic       Mode_ack,
   output logic       Wrap
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, SWITCH} state_t;
   state_t     state_q, state_d;
   logic [1:0] mode_q, mode_d, pend_q, pend_d;
   logic [3:0] d_q, d_d, count_q, count_d;
   logic       busy_q, busy_d, ack_q, ack_d, wrap_q, wrap_d;
   logic [3:0] step, init_cnt;
   logic       roll, ring_ok;
   assign D        = d_q;
   assign Count    = count_q;
   assign Busy     = busy_q;
   assign Mode_ack = ack_q;
   assign Wrap     = wrap_q;
   // Out-of-range BCD values and non-one-hot ring values recover to the mode's base without a rollover.
   always_comb begin
      ring_ok  = (count_q == 4'd1) || (count_q == 4'd2) || (count_q == 4'd4);
      init_cnt = (pend_q == 2'd1) ? 4'hF : (pend_q == 2'd3) ? 4'h1 : 4'h0;
      step     = 4'd0;
      roll     = 1'b0;
      case (mode_q)
         2'd0: begin
            step = count_q + 4'd1;
            roll = count_q == 4'hF;
         end
         2'd1: begin
            step = count_q - 4'd1;
            roll = count_q == 4'h0;
         end
         2'd2: begin
            step = (count_q < 4'd9) ? count_q + 4'd1 : 4'd0;
            roll = count_q == 4'd9;
         end
         default: begin
            step = ring_ok ? {count_q[2:0], 1'b0} : 4'd1;
            roll = count_q == 4'd8;
         end
      endcase
   end
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      pend_d  = pend_q;
      count_d = count_q;
      ack_d   = 1'b0;
      wrap_d  = 1'b0;
      case (state_q)
         SWITCH: begin
            mode_d  = pend_q;
            count_d = init_cnt;
            ack_d   = 1'b1;
            state_d = IDLE;
         end
         RUN: begin
            if (Mode_load) begin
               pend_d  = Mode_req;
               state_d = SWITCH;
            end else if (Stop) begin
               state_d = PAUSE;
            end else if (Tick) begin
               count_d = step;
               wrap_d  = roll;
            end
         end
         default: begin
            if (Mode_load) begin
               pend_d  = Mode_req;
               state_d = SWITCH;
            end else if (Start && !Stop) begin
               state_d = RUN;
            end
         end
      endcase
      busy_d = state_d == RUN;
      d_d    = 4'b0001 << mode_d;
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         mode_q  <= 2'd0;
         pend_q  <= 2'd0;
         d_q     <= 4'b0001;
         count_q <= 4'd0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         pend_q  <= pend_d;
         d_q     <= d_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         wrap_q  <= wrap_d;
      end
   end
endmodule

// File: doc/counter_mode_sequencer.md
COUNTER_MODE_SEQUENCER -- requirements
Module: counter_mode_sequencer

Interface
REQ-001 SHALL have port Clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous, active-high; sampled on rising Clk.
REQ-003 SHALL have port Mode_req, input, 2, requested counting mode (00 binary up, 01 binary down, 10 BCD up, 11 ring).
REQ-004 SHALL have port Mode_load, input, 1, mode-change request; sampled each cycle.
REQ-005 SHALL have port Start, input, 1, start or resume counting.
REQ-006 SHALL have port Stop, input, 1, pause counting.
REQ-007 SHALL have port Tick, input, 1, one-cycle count-enable strobe from the divider.
REQ-008 SHALL have port D, output, 4, registered one-hot active mode (00->0001, 01->0010, 10->0100, 11->1000).
REQ-009 SHALL have port Count, output, 4, registered counter value.
REQ-010 SHALL have port Busy, output, 1, high while in state RUN.
REQ-011 SHALL have port Mode_ack, output, 1, one-cycle pulse when a requested mode takes effect.
REQ-012 SHALL have port Wrap, output, 1, one-cycle pulse on terminal-count rollover.

Function
REQ-013 SHALL implement the states IDLE, RUN, PAUSE and SWITCH; all outputs SHALL be registered.
REQ-014 SHALL apply input priority Mode_load > Stop > Start > Tick in every cycle.
REQ-015 IDLE: Mode_load -> SWITCH; else Start -> RUN; else hold.
REQ-016 RUN: Mode_load -> SWITCH; else Stop -> PAUSE with no advance; else Tick advances Count by one step and state stays RUN.
REQ-017 PAUSE: Mode_load -> SWITCH; else Start -> RUN; else hold, with Count frozen.
REQ-018 On entry to SWITCH, Mode_req SHALL be latched into the pending register.
REQ-019 Mode_load, Start, Stop and Tick SHALL be ignored while in SWITCH.
REQ-020 SWITCH SHALL last exactly one cycle, then:
- mode := pending
- D updated
- Count := initial value of the new mode
- state -> IDLE
- Mode_ack = 1 for that one cycle only.
REQ-021 Mode_load asserted at edge k SHALL give Mode_ack, new D and initialised Count visible after edge k+2.
REQ-022 Initial values SHALL be: up 0000, down 1111, BCD 0000, ring 0001.
REQ-023 Step rules SHALL be:
- up: +1 mod 16
- down: -1 mod 16
- BCD: 0..9, then 9->0
- ring: rotate left, 1000->0001.
REQ-024 Wrap SHALL pulse for the cycle after each rollover advance: up 15->0, down 0->15, BCD 9->0, ring 1000->0001; otherwise Wrap = 0.
REQ-025 In BCD mode, Count > 9 SHALL map to 0000 on the next advance, with no Wrap.
REQ-026 In ring mode, a non-one-hot Count SHALL map to 0001 on the next advance, with no Wrap.
REQ-027 Tick outside RUN SHALL have no effect.
REQ-028 Start and Stop asserted together in RUN SHALL give PAUSE.
REQ-029 Start and Stop asserted together in IDLE or PAUSE SHALL give no transition.
REQ-030 Tick held high continuously in RUN SHALL advance Count every cycle.
REQ-031 Mode_load with Mode_req equal to the current mode SHALL still pass through SWITCH, reinitialise Count and pulse Mode_ack.

Reset
REQ-032 Reset = 1 SHALL override all inputs and, after the edge, give:
- state IDLE, mode 00, pending 00
- D = 0001, Count = 0000
- Busy = 0, Mode_ack = 0, Wrap = 0.
REQ-033 Reset asserted mid-RUN or mid-SWITCH SHALL discard the pending mode and emit no Mode_ack or Wrap.
REQ-034 The first cycle after Reset deasserts SHALL accept inputs normally.

Verification
REQ-035 Bench SHALL cover: Reset, then Start, then 17 Ticks in mode 00 -> Count 1..15, 0, 1; Wrap high for one cycle after the 16th Tick; Busy = 1 throughout.
REQ-036 Bench SHALL cover: Mode_req = 01 with a Mode_load pulse -> two edges later D = 0010, Count = 1111, Mode_ack one cycle, state IDLE; then Start and 16 Ticks -> Count 14..0, then 15 with Wrap.
REQ-037 Bench SHALL cover: mode 10 in RUN with Ticks -> 0..9, then 0 with Wrap; Stop together with Tick at Count = 5 -> Count stays 5, Busy = 0; Start resumes at 6.
REQ-038 Bench SHALL cover: mode 11 with Ticks -> 0001, 0010, 0100, 1000, then 0001 with Wrap; Start and Stop together in RUN -> PAUSE.
REQ-039 Bench SHALL cover: Reset asserted at Count = 7 in RUN with Tick high -> next cycle Count = 0000, D = 0001, Busy = 0, no Wrap.
REQ-040 Bench SHALL cover: Mode_load again during SWITCH with a different Mode_req -> ignored; first request applied, single Mode_ack.
